// File: rtl/uart_ctrl.sv
// Full-duplex 16x-oversampled UART: shared baud tick, TX/RX engines, RX FIFO with
// per-word error tags, and an internal loopback path for self-test.
module uart_ctrl #(
    parameter int CLK_HZ     = 100_000_000,
    parameter int BAUD       = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int FIFO_DEPTH = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_line,
    output logic                 tx_line,
    input  logic                 loopback,
    input  logic [DATA_BITS-1:0] tx_data,
    input  logic                 tx_valid,
    output logic                 tx_ready,
    output logic [DATA_BITS-1:0] rx_data,
    output logic                 rx_valid,
    input  logic                 rx_ready,
    output logic                 rx_parity_err,
    output logic                 rx_frame_err,
    output logic                 rx_overrun
);

    localparam longint DIV_RAW   = (longint'(CLK_HZ) + longint'(BAUD) * 8) / (longint'(BAUD) * 16);
    localparam int     DIV       = (DIV_RAW < 1) ? 1 : int'(DIV_RAW);
    localparam int     DIV_W     = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int     AW        = $clog2(FIFO_DEPTH);
    localparam int     WW        = DATA_BITS + 2;
    localparam logic [3:0] LAST_DATA = 4'(DATA_BITS - 1);
    localparam logic [3:0] LAST_STOP = 4'(STOP_BITS - 1);

    // ------------------------------------------------------------------
    // Baud tick generator: one tick every DIV clocks, 16 ticks per bit
    // ------------------------------------------------------------------
    logic [DIV_W-1:0] baud_cnt_q, baud_cnt_d;
    logic             tick;

    always_comb begin
        tick       = (baud_cnt_q == DIV_W'(DIV - 1));
        baud_cnt_d = tick ? '0 : baud_cnt_q + DIV_W'(1);
    end

    always_ff @(posedge clk) begin
        if (rst) baud_cnt_q <= '0;
        else     baud_cnt_q <= baud_cnt_d;
    end

    // ------------------------------------------------------------------
    // TX engine
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        TX_IDLE, TX_WAIT, TX_START, TX_DATA, TX_PAR, TX_STOP
    } tx_state_t;

    tx_state_t            tx_state_q;
    logic [DATA_BITS-1:0] tx_shift_q;
    logic                 tx_par_q;
    logic [3:0]           tx_tick_q;
    logic [3:0]           tx_bit_q;
    logic                 tx_ser_q;
    logic                 tx_rdy_q;
    logic                 tx_bit_end;

    assign tx_bit_end = tick && (tx_tick_q == 4'd15);

    // The 4-bit tick counter wraps on its own at each bit boundary, so it is
    // zero whenever a new bit (or the idle state) begins.
    always_ff @(posedge clk) begin
        if (rst) begin
            tx_state_q <= TX_IDLE;
            tx_shift_q <= '0;
            tx_par_q   <= 1'b0;
            tx_tick_q  <= '0;
            tx_bit_q   <= '0;
            tx_ser_q   <= 1'b1;
            tx_rdy_q   <= 1'b1;
        end else begin
            if (tick && tx_state_q != TX_IDLE && tx_state_q != TX_WAIT)
                tx_tick_q <= tx_tick_q + 4'd1;
            case (tx_state_q)
                TX_IDLE: begin
                    if (tx_valid && tx_ready) begin
                        tx_shift_q <= tx_data;
                        tx_par_q   <= (PARITY == 1) ? ~^tx_data : ^tx_data;
                        tx_rdy_q   <= 1'b0;
                        tx_state_q <= TX_WAIT;
                    end
                end
                TX_WAIT: begin
                    if (tick) begin
                        tx_ser_q   <= 1'b0;
                        tx_tick_q  <= '0;
                        tx_state_q <= TX_START;
                    end
                end
                TX_START: begin
                    if (tx_bit_end) begin
                        tx_ser_q   <= tx_shift_q[0];
                        tx_shift_q <= tx_shift_q >> 1;
                        tx_bit_q   <= '0;
                        tx_state_q <= TX_DATA;
                    end
                end
                TX_DATA: begin
                    if (tx_bit_end) begin
                        if (tx_bit_q == LAST_DATA) begin
                            tx_bit_q <= '0;
                            if (PARITY != 0) begin
                                tx_ser_q   <= tx_par_q;
                                tx_state_q <= TX_PAR;
                            end else begin
                                tx_ser_q   <= 1'b1;
                                tx_state_q <= TX_STOP;
                            end
                        end else begin
                            tx_ser_q   <= tx_shift_q[0];
                            tx_shift_q <= tx_shift_q >> 1;
                            tx_bit_q   <= tx_bit_q + 4'd1;
                        end
                    end
                end
                TX_PAR: begin
                    if (tx_bit_end) begin
                        tx_ser_q   <= 1'b1;
                        tx_bit_q   <= '0;
                        tx_state_q <= TX_STOP;
                    end
                end
                TX_STOP: begin
                    if (tx_bit_end) begin
                        if (tx_bit_q == LAST_STOP) begin
                            tx_rdy_q   <= 1'b1;
                            tx_state_q <= TX_IDLE;
                        end else begin
                            tx_bit_q <= tx_bit_q + 4'd1;
                        end
                    end
                end
                default: tx_state_q <= TX_IDLE;
            endcase
        end
    end

    assign tx_ready = tx_rdy_q & ~rst;
    assign tx_line  = loopback | tx_ser_q;

    // ------------------------------------------------------------------
    // RX input conditioning
    // ------------------------------------------------------------------
    logic sync1_q, sync1_d, sync2_q, sync2_d, rx_prev_q, rx_prev_d;
    logic rx_in;

    always_comb begin
        rx_in     = loopback ? tx_ser_q : sync2_q;
        sync1_d   = rx_line;
        sync2_d   = sync1_q;
        rx_prev_d = rx_in;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            sync1_q   <= 1'b1;
            sync2_q   <= 1'b1;
            rx_prev_q <= 1'b1;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            rx_prev_q <= rx_prev_d;
        end
    end

    // ------------------------------------------------------------------
    // RX engine
    // ------------------------------------------------------------------
    typedef enum logic [2:0] {
        RX_IDLE, RX_START, RX_DATA, RX_PAR, RX_STOP, RX_BREAK
    } rx_state_t;

    rx_state_t            rx_state_q;
    logic [DATA_BITS-1:0] rx_shift_q;
    logic                 rx_par_bit_q;
    logic [3:0]           rx_tick_q;
    logic [3:0]           rx_bit_q;
    logic                 push_q;
    logic [WW-1:0]        push_word_q;
    logic                 rx_mid;
    logic                 rx_perr;

    always_comb begin
        rx_mid  = tick && (rx_tick_q == 4'd15);
        rx_perr = (PARITY != 0) &&
                  (rx_par_bit_q != ((PARITY == 1) ? ~^rx_shift_q : ^rx_shift_q));
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_state_q   <= RX_IDLE;
            rx_shift_q   <= '0;
            rx_par_bit_q <= 1'b0;
            rx_tick_q    <= '0;
            rx_bit_q     <= '0;
            push_q       <= 1'b0;
            push_word_q  <= '0;
        end else begin
            push_q <= 1'b0;
            if (tick && (rx_state_q == RX_DATA || rx_state_q == RX_PAR || rx_state_q == RX_STOP))
                rx_tick_q <= rx_tick_q + 4'd1;
            case (rx_state_q)
                RX_IDLE: begin
                    if (rx_prev_q && !rx_in) begin
                        rx_tick_q  <= '0;
                        rx_state_q <= RX_START;
                    end
                end
                RX_START: begin
                    if (tick) begin
                        if (rx_tick_q == 4'd7) begin
                            rx_tick_q <= '0;
                            rx_bit_q  <= '0;
                            rx_state_q <= rx_in ? RX_IDLE : RX_DATA;
                        end else begin
                            rx_tick_q <= rx_tick_q + 4'd1;
                        end
                    end
                end
                RX_DATA: begin
                    if (rx_mid) begin
                        rx_shift_q <= {rx_in, rx_shift_q[DATA_BITS-1:1]};
                        if (rx_bit_q == LAST_DATA)
                            rx_state_q <= (PARITY != 0) ? RX_PAR : RX_STOP;
                        else
                            rx_bit_q <= rx_bit_q + 4'd1;
                    end
                end
                RX_PAR: begin
                    if (rx_mid) begin
                        rx_par_bit_q <= rx_in;
                        rx_state_q   <= RX_STOP;
                    end
                end
                RX_STOP: begin
                    if (rx_mid) begin
                        push_q      <= 1'b1;
                        push_word_q <= {~rx_in, rx_perr, rx_shift_q};
                        rx_state_q  <= rx_in ? RX_IDLE : RX_BREAK;
                    end
                end
                RX_BREAK: begin
                    if (rx_in) rx_state_q <= RX_IDLE;
                end
                default: rx_state_q <= RX_IDLE;
            endcase
        end
    end

    // ------------------------------------------------------------------
    // RX FIFO, first-word-fall-through, wrap-bit pointers
    // ------------------------------------------------------------------
    logic [WW-1:0] mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic          ovr_q, ovr_d;
    logic          fifo_empty, fifo_full, pop, push_ok;
    logic [WW-1:0] head;

    always_comb begin
        fifo_empty = (wr_ptr_q == rd_ptr_q);
        fifo_full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                     (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
        pop        = !fifo_empty && rx_ready;
        // A pop in the same cycle frees the slot, so a full FIFO can still take the push.
        push_ok    = push_q && (!fifo_full || pop);
        wr_ptr_d   = wr_ptr_q + {{AW{1'b0}}, push_ok};
        rd_ptr_d   = rd_ptr_q + {{AW{1'b0}}, pop};
        ovr_d      = push_q && fifo_full && !pop;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            ovr_q    <= 1'b0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            ovr_q    <= ovr_d;
        end
    end

    always_ff @(posedge clk) begin
        if (push_ok) mem[wr_ptr_q[AW-1:0]] <= push_word_q;
    end

    assign head          = mem[rd_ptr_q[AW-1:0]];
    assign rx_valid      = !fifo_empty;
    assign rx_data       = rx_valid ? head[DATA_BITS-1:0] : '0;
    assign rx_parity_err = rx_valid & head[DATA_BITS];
    assign rx_frame_err  = rx_valid & head[DATA_BITS+1];
    assign rx_overrun    = ovr_q;

endmodule

// File: tb/tb_uart_ctrl.sv
// Scoreboard bench for uart_ctrl at 16 MHz / 1 Mbaud (one tick per clock), 8E1, 16-deep FIFO.
module tb_uart_ctrl;
    localparam int CLK_HZ  = 16_000_000;
    localparam int BAUD    = 1_000_000;
    localparam int DW      = 8;
    localparam int PAR     = 2;
    localparam int SB      = 1;
    localparam int DEPTH   = 16;
    localparam int BIT_CYC = 16;
    localparam int NBITS   = 1 + DW + ((PAR != 0) ? 1 : 0) + SB;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          rx_line = 1'b1;
    logic          loopback = 1'b0;
    logic [DW-1:0] tx_data = '0;
    logic          tx_valid = 1'b0;
    logic          rx_ready = 1'b0;
    logic          tx_line, tx_ready, rx_valid, rx_parity_err, rx_frame_err, rx_overrun;
    logic [DW-1:0] rx_data;

    uart_ctrl #(
        .CLK_HZ(CLK_HZ), .BAUD(BAUD), .DATA_BITS(DW),
        .PARITY(PAR), .STOP_BITS(SB), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst), .rx_line(rx_line), .tx_line(tx_line),
        .loopback(loopback), .tx_data(tx_data), .tx_valid(tx_valid),
        .tx_ready(tx_ready), .rx_data(rx_data), .rx_valid(rx_valid),
        .rx_ready(rx_ready), .rx_parity_err(rx_parity_err),
        .rx_frame_err(rx_frame_err), .rx_overrun(rx_overrun)
    );

    always #5 clk = ~clk;

    int vectors = 0;
    int miscompares = 0;
    int ovr_seen = 0;
    int exp_ovr = 0;
    logic [DW+1:0] exp_q[$];
    bit lv_q[$];

    task automatic check(input bit ok, input string name, input int act, input int req);
        vectors++;
        if (!ok) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    function automatic bit ref_par(input logic [DW-1:0] d);
        return (PAR == 1) ? ~^d : ^d;
    endfunction

    // Line levels of one frame, one entry per bit period
    function automatic void build_frame(input logic [DW-1:0] d, input bit bad_par, input bit stop_val);
        lv_q.delete();
        lv_q.push_back(1'b0);
        for (int i = 0; i < DW; i++) lv_q.push_back(d[i]);
        if (PAR != 0) lv_q.push_back(ref_par(d) ^ bad_par);
        for (int i = 0; i < SB; i++) lv_q.push_back((i == 0) ? stop_val : 1'b1);
    endfunction

    // Monitor: pops the scoreboard whenever the DUT hands over a word
    always @(negedge clk) begin
        if (!rst && rx_overrun) ovr_seen++;
        if (!rst && rx_valid && rx_ready) begin
            logic [DW+1:0] act;
            act = {rx_frame_err, rx_parity_err, rx_data};
            if (exp_q.size() == 0) begin
                check(1'b0, "rx_unexpected_word", int'(act), 0);
            end else begin
                logic [DW+1:0] e;
                e = exp_q.pop_front();
                $display("rx pop data=%02h pe=%0d fe=%0d", rx_data, rx_parity_err, rx_frame_err);
                check(act === e, "rx_word", int'(act), int'(e));
            end
        end
    end

    task automatic rx_send(input logic [DW-1:0] d, input bit bad_par, input bit stop_val, input int hold_low);
        logic [DW+1:0] e;
        build_frame(d, bad_par, stop_val);
        e = {~stop_val, bad_par & (PAR != 0), d};
        if (!rx_ready && exp_q.size() == DEPTH) exp_ovr++;
        else exp_q.push_back(e);
        $display("rx frame data=%02h bad_par=%0d stop=%0d", d, bad_par, stop_val);
        foreach (lv_q[i]) begin
            rx_line = lv_q[i];
            repeat (BIT_CYC) @(posedge clk);
            #1;
        end
        if (hold_low > 0) begin
            rx_line = 1'b0;
            repeat (hold_low * BIT_CYC) @(posedge clk);
            #1;
        end
        rx_line = 1'b1;
        repeat (2 * BIT_CYC) @(posedge clk);
        #1;
    endtask

    // Cycle-exact check of the serial waveform on tx_line
    task automatic tx_exact(input logic [DW-1:0] d);
        int n;
        bit ok;
        build_frame(d, 1'b0, 1'b1);
        $display("tx frame data=%02h (exact)", d);
        check(tx_ready === 1'b1, "tx_ready_idle", int'(tx_ready), 1);
        tx_data = d; tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        check(tx_ready === 1'b0, "tx_ready_drop", int'(tx_ready), 0);
        n = 0;
        while (tx_line !== 1'b0 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        check(n == 1, "tx_start_latency", n, 1);
        for (int b = 0; b < NBITS; b++) begin
            ok = 1'b1;
            for (int c = 0; c < BIT_CYC; c++) begin
                if (tx_line !== lv_q[b] || tx_ready !== 1'b0) ok = 1'b0;
                @(posedge clk); #1;
            end
            check(ok, $sformatf("tx_bit%0d", b), int'(!lv_q[b]), int'(lv_q[b]));
        end
        check(tx_ready === 1'b1 && tx_line === 1'b1, "tx_ready_return", int'({tx_ready, tx_line}), 3);
    endtask

    task automatic tx_loop(input logic [DW-1:0] d);
        int n;
        bit went_low;
        went_low = 1'b0;
        n = 0;
        while (tx_ready !== 1'b1 && n < 1000) begin
            @(posedge clk); #1; n++;
        end
        $display("tx frame data=%02h (loopback)", d);
        exp_q.push_back({2'b00, d});
        tx_data = d; tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        n = 0;
        do begin
            if (tx_line !== 1'b1) went_low = 1'b1;
            @(posedge clk); #1; n++;
        end while (tx_ready !== 1'b1 && n < 1000);
        check(n < 1000, "lb_tx_complete", n, NBITS * BIT_CYC);
        check(!went_low, "lb_tx_line_idle", int'(!went_low), 1);
        repeat (4) @(posedge clk);
        #1;
    endtask

    task automatic wait_drain();
        int n;
        n = 0;
        while (exp_q.size() != 0 && n < 3000) begin
            @(posedge clk); #1; n++;
        end
        check(exp_q.size() == 0, "scoreboard_drain", exp_q.size(), 0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        rst = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        check(tx_line === 1'b1, "rst_tx_line", int'(tx_line), 1);
        check(tx_ready === 1'b0, "rst_tx_ready", int'(tx_ready), 0);
        check(rx_valid === 1'b0 && rx_overrun === 1'b0, "rst_rx_valid_ovr", int'({rx_valid, rx_overrun}), 0);
        check(rx_parity_err === 1'b0 && rx_frame_err === 1'b0, "rst_err_flags",
              int'({rx_frame_err, rx_parity_err}), 0);
        rst = 1'b0;
        @(posedge clk); #1;
        check(tx_ready === 1'b1, "post_rst_tx_ready", int'(tx_ready), 1);

        // Exact TX waveform: directed then random
        tx_exact(8'hA5);
        tx_exact(8'($urandom));
        tx_exact(8'($urandom));

        // Loopback: RX fed from TX, tx_line held high
        rx_ready = 1'b1;
        loopback = 1'b1;
        tx_loop(8'h3C);
        for (int i = 0; i < 6; i++) tx_loop(8'($urandom));
        wait_drain();
        loopback = 1'b0;
        repeat (4) @(posedge clk);
        #1;

        // External frames: directed parity error, then random with occasional bad parity
        rx_send(8'h01, 1'b1, 1'b1, 0);
        for (int i = 0; i < 10; i++) rx_send(8'($urandom), ($urandom_range(0, 2) == 0), 1'b1, 0);

        // Break: stop bit low then line held low for 40 bit times
        rx_send(8'h55, 1'b0, 1'b0, 40);
        rx_send(8'h12, 1'b0, 1'b1, 0);
        wait_drain();

        // Short low glitch must not start a frame
        rx_ready = 1'b0;
        rx_line = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        rx_line = 1'b1;
        repeat (4 * BIT_CYC) @(posedge clk);
        #1;
        check(rx_valid === 1'b0, "glitch_no_push", int'(rx_valid), 0);

        // Overrun: 17 frames into a 16-deep FIFO with no consumer
        for (int i = 0; i <= DEPTH; i++) rx_send(8'(i), 1'b0, 1'b1, 0);
        check(ovr_seen == exp_ovr, "overrun_pulses", ovr_seen, exp_ovr);
        check(rx_valid === 1'b1 && rx_data === 8'h00, "full_head", int'(rx_data), 0);
        rx_ready = 1'b1;
        wait_drain();
        repeat (3) @(posedge clk);
        #1;
        check(rx_valid === 1'b0, "drain_empty", int'(rx_valid), 0);

        // Reset in the middle of a TX frame with a word waiting in the FIFO
        rx_ready = 1'b0;
        rx_send(8'($urandom), 1'b0, 1'b1, 0);
        check(rx_valid === 1'b1, "pre_reset_valid", int'(rx_valid), 1);
        tx_data = 8'($urandom); tx_valid = 1'b1;
        @(posedge clk); #1;
        tx_valid = 1'b0;
        n = 0;
        while (tx_line !== 1'b0 && n < 50) begin
            @(posedge clk); #1; n++;
        end
        repeat (5 + $urandom_range(0, 8)) @(posedge clk);
        #1;
        rst = 1'b1;
        exp_q.delete();
        @(posedge clk); #1;
        check(tx_line === 1'b1 && tx_ready === 1'b0, "in_rst_tx", int'({tx_line, tx_ready}), 2);
        rst = 1'b0;
        @(posedge clk); #1;
        check(tx_line === 1'b1 && tx_ready === 1'b1, "post_rst_tx", int'({tx_line, tx_ready}), 3);
        check(rx_valid === 1'b0, "post_rst_fifo_empty", int'(rx_valid), 0);
        repeat (20 * BIT_CYC) @(posedge clk);
        #1;
        check(rx_valid === 1'b0 && tx_line === 1'b1, "post_rst_quiet", int'({rx_valid, tx_line}), 1);

        check(ovr_seen == exp_ovr, "overrun_total", ovr_seen, exp_ovr);
        check(exp_q.size() == 0, "scoreboard_final", exp_q.size(), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
